shifter_pack: RTL and testbench
===============================

Name: shifter_pack

Overview:
Bitstream packer, the write side of the funnel-shifter bitfield extractor used by the stream reader. It accepts variable-length fields of 1..32 bits, concatenates them in a 64-bit accumulator, and emits packed 32-bit words. A flush request pads and emits the trailing partial word. It sits between field producers (encoders) and the 32-bit word sink, using valid/ready handshakes on both sides.

Parameters:
MSB_FIRST, 0, 0 = first stream bit lands in out_data[0] and field bit 0 goes first; 1 = first stream bit lands in out_data[31] and field bit len-1 goes first.

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  field offered
in_ready  output  1  field accepted when in_valid && in_ready
in_data  input  32  field value; bits at and above in_len are ignored (masked)
in_len  input  6  field length; 0 = no-op (consumed, nothing added); 33..63 clamped to 32
flush  input  1  request to emit all held bits, sampled on any edge where no flush is pending
out_valid  output  1  word available
out_ready  input  1  word consumed when out_valid && out_ready
out_data  output  32  packed word
out_bits  output  6  valid bits in out_data: 32 for full words, 1..31 for the final flushed word
flush_done  output  1  one-cycle pulse when a flush has fully drained

Behaviour:
- State: acc[63:0], count[6:0] (0..63 bits held), flush_pend. Two-state FSM: FILL (flush_pend=0), DRAIN (flush_pend=1).
- Reset (async, resetn=0): acc=0, count=0, state FILL, out_valid=0, out_data=0, out_bits=0, flush_done=0, in_ready=1. A partial word is discarded if reset arrives mid-operation.
- in_ready = (state==FILL) && (count<32). At most 63 bits are ever held.
- Input fire: the masked field is appended after the existing count bits, and count += len. LSB-first: acc |= field<<count. MSB-first: the field's MSB goes to the next free position below acc[63-count].
- out_valid = (count>=32) || (state==DRAIN && count>0). out_data is the oldest 32 bits: LSB-first acc[31:0], MSB-first acc[63:32]. Unfilled bits are 0: high bits in LSB-first mode, low bits in MSB-first mode (partial words are right- or left-justified).
- out_bits = min(count,32) while out_valid, else 0.
- Output fire: acc shifts out the consumed 32 bits with zero fill, and count -= out_bits.
- Input and output never fire on the same edge, because in_ready requires count<32 and FILL.
- out_data and out_bits stay stable while out_valid && !out_ready.
- Latency: a word completed by an input fire shows out_valid on the next cycle. No combinational path from in_* to out_*, or from out_ready to in_ready.
- FILL→DRAIN when flush=1 on an edge. An input firing on the same edge is appended first, and the flush then covers it.
- DRAIN:
  - in_ready=0, and flush is ignored.
  - Full words drain first, then the partial word.
  - When count reaches 0 (or is already 0 at entry): return to FILL, and flush_done=1 for exactly the following cycle.
- Flush with count=0: no output word; flush_done pulses on the cycle after flush is sampled.

Test Plan:
1. LSB-first: fields (0x5,3), (0x1F,5), (0xABCDEF,24) → one word out_data=0xABCDEFFD, out_bits=32; count returns to 0, in_ready=1.
2. MSB_FIRST=1, same three fields → out_data=0xBFABCDEF, out_bits=32.
3. LSB-first straddle + flush: (0xFF,8), (0xAAAAAAAA,32), then flush → 0xAAAAAAFF/32, then 0x000000AA/8. flush_done pulses one cycle after the second handshake; then FILL with in_ready=1.
4. Backpressure + masking: in_data=0xFFFFFFFF len 4, then 0x0 len 28, hold out_ready=0 for 5 cycles → out_valid held, out_data=0x0000000F stable, in_ready=0 for all 5 cycles; the word is delivered exactly once after out_ready=1.
5. Flush corners:
   - flush with count=0 → no out_valid; flush_done high exactly one cycle later.
   - flush with in_valid (0x3,2) on the same edge, LSB-first → out_data=0x00000003, out_bits=2.
   - MSB-first, same stimulus → out_data=0xC0000000, out_bits=2.
6. Reset mid-operation: with count=20, pulse resetn=0 asynchronously (between edges) → out_valid=0 and in_ready=1 immediately. Next fields (0x12345678,32) → out_data=0x12345678 with no stale bits.

Source files
------------

// File: rtl/shifter_pack.sv
// Bitstream packer: appends 1..32-bit fields into a 64-bit accumulator
// and emits packed 32-bit words, with flush of the trailing partial word.
module shifter_pack #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [5:0]  in_len,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_bits,
  output logic        flush_done
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_nxt;
  logic [63:0] acc;
  logic [63:0] acc_nxt;
  logic [6:0]  count;
  logic [6:0]  count_nxt;
  logic        done_nxt;

  logic [5:0]  len_c;
  logic [31:0] mask;
  logic [31:0] field;
  logic [63:0] ins;
  logic [6:0]  msb_sh;
  logic        in_fire;
  logic        out_fire;

  always_comb begin
    len_c = (in_len > 6'd32) ? 6'd32 : in_len;
    if (len_c == 6'd32) begin
      mask = '1;
    end else begin
      mask = (32'd1 << len_c) - 32'd1;
    end
    field  = in_data & mask;
    msb_sh = 7'd32 - {1'b0, len_c};
    // MSB-first: left-justify the field, then slide it below held bits
    if (MSB_FIRST) begin
      ins = ({field, 32'd0} << msb_sh) >> count;
    end else begin
      ins = {32'd0, field} << count;
    end
  end

  assign in_ready  = (state == FILL) && (count < 7'd32);
  assign out_valid = (count >= 7'd32) ||
                     ((state == DRAIN) && (count != 7'd0));
  assign out_data  = MSB_FIRST ? acc[63:32] : acc[31:0];

  always_comb begin
    out_bits = 6'd0;
    if (out_valid) begin
      out_bits = (count >= 7'd32) ? 6'd32 : count[5:0];
    end
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    acc_nxt   = acc;
    count_nxt = count;
    if (out_fire) begin
      acc_nxt   = MSB_FIRST ? (acc << 32) : (acc >> 32);
      count_nxt = count - {1'b0, out_bits};
    end else if (in_fire) begin
      acc_nxt   = acc | ins;
      count_nxt = count + {1'b0, len_c};
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (1'b1)
      (state == FILL) && flush: begin
        if (count_nxt == 7'd0) begin
          done_nxt = 1'b1;
        end else begin
          state_nxt = DRAIN;
        end
      end
      (state == DRAIN): begin
        if (count_nxt == 7'd0) begin
          state_nxt = FILL;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      count      <= '0;
      state      <= FILL;
      flush_done <= 1'b0;
    end else begin
      acc        <= acc_nxt;
      count      <= count_nxt;
      state      <= state_nxt;
      flush_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shifter_pack.sv
// Bench for shifter_pack: LSB- and MSB-first instances share stimulus,
// checked against a bit-queue model and fixed expected words.
module tb_shifter_pack;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [5:0]  in_len = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        l_ir, l_ov, l_fd, m_ir, m_ov, m_fd;
  logic [31:0] l_od, m_od;
  logic [5:0]  l_ob, m_ob;

  always #5 clk = ~clk;

  shifter_pack #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(l_ir),
    .in_data(in_data), .in_len(in_len),
    .flush(flush),
    .out_valid(l_ov), .out_ready(out_ready),
    .out_data(l_od), .out_bits(l_ob),
    .flush_done(l_fd)
  );

  shifter_pack #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(m_ir),
    .in_data(in_data), .in_len(in_len),
    .flush(flush),
    .out_valid(m_ov), .out_ready(out_ready),
    .out_data(m_od), .out_bits(m_ob),
    .flush_done(m_fd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: stream bits queued on input, popped on output
  bit ql[$];
  bit qm[$];
  bit pend = 1'b0;
  bit fd = 1'b0;
  int m_sz, m_lc, m_k;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ql.delete();
      qm.delete();
      pend = 1'b0;
      fd = 1'b0;
    end else begin
      m_sz = ql.size();
      fd = 1'b0;
      if ((m_sz >= 32 || (pend && m_sz > 0)) && out_ready) begin
        m_k = (m_sz >= 32) ? 32 : m_sz;
        repeat (m_k) begin
          void'(ql.pop_front());
          void'(qm.pop_front());
        end
      end else if (!pend && m_sz < 32 && in_valid) begin
        m_lc = (in_len > 6'd32) ? 32 : int'(in_len);
        for (int i = 0; i < m_lc; i++) ql.push_back(in_data[i]);
        for (int i = m_lc - 1; i >= 0; i--) qm.push_back(in_data[i]);
      end
      if (!pend && flush) pend = 1'b1;
      if (pend && ql.size() == 0) begin
        pend = 1'b0;
        fd = 1'b1;
      end
    end
  end

  logic [37:0] cap_l[$];
  logic [37:0] cap_m[$];
  int e_sz, e_bits;
  logic [31:0] e_wl, e_wm;
  logic e_v, e_r;

  always @(negedge clk) begin
    if (resetn) begin
      e_sz = ql.size();
      e_bits = (e_sz >= 32) ? 32 : e_sz;
      e_wl = '0;
      e_wm = '0;
      for (int i = 0; i < e_bits; i++) begin
        e_wl[i] = ql[i];
        e_wm[31-i] = qm[i];
      end
      e_v = (e_sz >= 32) || (pend && e_sz > 0);
      e_r = !pend && (e_sz < 32);
      chk("l_valid", l_ov, e_v);
      chk("m_valid", m_ov, e_v);
      chk("l_ready", l_ir, e_r);
      chk("m_ready", m_ir, e_r);
      chk("l_fdone", l_fd, fd);
      chk("m_fdone", m_fd, fd);
      chk("l_bits", l_ob, e_v ? e_bits : 0);
      chk("m_bits", m_ob, e_v ? e_bits : 0);
      if (e_v) begin
        chk("l_data", l_od, e_wl);
        chk("m_data", m_od, e_wm);
      end
      if (l_ov && out_ready) cap_l.push_back({l_ob, l_od});
      if (m_ov && out_ready) cap_m.push_back({m_ob, m_od});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [5:0] l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_len = l;
    do begin
      @(negedge clk);
      n++;
    end while (!l_ir && n < 100);
    if (!l_ir) chk("send_timeout", l_ir, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ql.size() != 0 || pend) && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", ql.size(), 0);
    tick();
    tick();
  endtask

  task automatic expect_caps(input string nm, input int n,
                             input logic [37:0] l0, input logic [37:0] m0,
                             input logic [37:0] l1, input logic [37:0] m1);
    chk({nm, " l_count"}, cap_l.size(), n);
    chk({nm, " m_count"}, cap_m.size(), n);
    if (n > 0 && cap_l.size() > 0) chk({nm, " l0"}, cap_l[0], l0);
    if (n > 0 && cap_m.size() > 0) chk({nm, " m0"}, cap_m[0], m0);
    if (n > 1 && cap_l.size() > 1) chk({nm, " l1"}, cap_l[1], l1);
    if (n > 1 && cap_m.size() > 1) chk({nm, " m1"}, cap_m[1], m1);
    cap_l.delete();
    cap_m.delete();
  endtask

  typedef struct {
    logic [31:0] data;
    logic [5:0]  len;
    int          nw;
    logic [37:0] wl;
    logic [37:0] wm;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_hs, fd_at, fd_n;
    vecs[0] = '{32'h3,        6'd2,  1, {6'd2,  32'h3},
                                        {6'd2,  32'hC0000000}};
    vecs[1] = '{32'hFFFFFFFF, 6'd1,  1, {6'd1,  32'h1},
                                        {6'd1,  32'h80000000}};
    vecs[2] = '{32'hDEADBEEF, 6'd40, 1, {6'd32, 32'hDEADBEEF},
                                        {6'd32, 32'hDEADBEEF}};
    vecs[3] = '{32'h1234,     6'd8,  1, {6'd8,  32'h34},
                                        {6'd8,  32'h34000000}};
    vecs[4] = '{32'hABC,      6'd0,  0, 38'd0, 38'd0};
    vecs[5] = '{32'h7FFFF,    6'd31, 1, {6'd31, 32'h0007FFFF},
                                        {6'd31, 32'h000FFFFE}};

    repeat (2) @(posedge clk);
    #1;
    chk("rst l_valid", l_ov, 0);
    chk("rst m_valid", m_ov, 0);
    chk("rst l_ready", l_ir, 1);
    chk("rst m_ready", m_ir, 1);
    chk("rst l_data", l_od, 0);
    chk("rst l_bits", l_ob, 0);
    chk("rst m_data", m_od, 0);
    chk("rst l_fdone", l_fd, 0);
    resetn = 1'b1;
    tick();

    send(32'h5, 6'd3);
    send(32'h1F, 6'd5);
    send(32'hABCDEF, 6'd24);
    wait_idle();
    expect_caps("t1", 1, {6'd32, 32'hABCDEFFD}, {6'd32, 32'hBFABCDEF},
                38'd0, 38'd0);
    chk("t1 ready", l_ir, 1);

    send(32'hFF, 6'd8);
    send(32'hAAAAAAAA, 6'd32);
    do_flush();
    last_hs = -1;
    fd_at = -1;
    fd_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (l_ov && out_ready) last_hs = c;
      if (l_fd) begin
        fd_n++;
        if (fd_at < 0) fd_at = c;
      end
    end
    chk("t3 fdone lag", fd_at - last_hs, 1);
    chk("t3 fdone pulses", fd_n, 1);
    tick();
    expect_caps("t3", 2, {6'd32, 32'hAAAAAAFF}, {6'd32, 32'hFFAAAAAA},
                {6'd8, 32'h000000AA}, {6'd8, 32'hAA000000});
    chk("t3 ready", l_ir, 1);

    out_ready = 1'b0;
    send(32'hFFFFFFFF, 6'd4);
    send(32'h0, 6'd28);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4 l_valid", l_ov, 1);
      chk("t4 l_data", l_od, 32'h0000000F);
      chk("t4 m_data", m_od, 32'hF0000000);
      chk("t4 ready", l_ir, 0);
    end
    tick();
    out_ready = 1'b1;
    wait_idle();
    expect_caps("t4", 1, {6'd32, 32'h0000000F}, {6'd32, 32'hF0000000},
                38'd0, 38'd0);

    do_flush();
    @(negedge clk);
    chk("t5a fdone", l_fd, 1);
    chk("t5a m_fdone", m_fd, 1);
    chk("t5a valid", l_ov, 0);
    @(negedge clk);
    chk("t5a fdone off", l_fd, 0);
    tick();
    expect_caps("t5a", 0, 38'd0, 38'd0, 38'd0, 38'd0);

    in_valid = 1'b1;
    in_data = 32'h3;
    in_len = 6'd2;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    wait_idle();
    expect_caps("t5b", 1, {6'd2, 32'h3}, {6'd2, 32'hC0000000},
                38'd0, 38'd0);

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].data, vecs[v].len);
      do_flush();
      wait_idle();
      expect_caps($sformatf("vec%0d", v), vecs[v].nw,
                  vecs[v].wl, vecs[v].wm, 38'd0, 38'd0);
    end

    send(32'hABCDE, 6'd20);
    out_ready = 1'b0;
    do_flush();
    @(negedge clk);
    chk("t6 drain valid", l_ov, 1);
    chk("t6 drain ready", l_ir, 0);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6 rst l_valid", l_ov, 0);
    chk("t6 rst m_valid", m_ov, 0);
    chk("t6 rst l_ready", l_ir, 1);
    chk("t6 rst m_ready", m_ir, 1);
    chk("t6 rst bits", l_ob, 0);
    #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    cap_l.delete();
    cap_m.delete();
    send(32'h12345678, 6'd32);
    wait_idle();
    expect_caps("t6", 1, {6'd32, 32'h12345678}, {6'd32, 32'h12345678},
                38'd0, 38'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
